turn_sequencer: RTL

- Game-logic side of the renderer's turn interface.
- Drives target x positions for two players, a one-cycle `pos_valid` strobe and `active_player`. It then waits for the renderer's `turn_done` before starting the next turn.
- Contains the dice source, tile bookkeeping, the question-box bonus move and win detection.
- Sits between the debounced roll button and the VGA UI renderer.

---
 rtl/game_pkg.sv | 23 ++
 rtl/dice_counter.sv | 17 +
 rtl/turn_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the board game: FSM states, tile/position widths
// and tile-to-pixel placement used by both the sequencer and renderer side.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROLL,
        ISSUE,
        WAIT,
        OVER
    } state_t;

    localparam int TILE_W = 4;
    localparam int X_W    = 10;
    localparam int DICE_W = 3;

    function automatic logic [X_W-1:0] tile_to_x(input logic [TILE_W-1:0] tile,
                                                 input int x0,
                                                 input int pitch);
        return X_W'(x0 + int'(tile) * pitch);
    endfunction

endpackage

// File: rtl/dice_counter.sv
// Free-running dice source cycling 1..DICE_MAX; the roll is whatever value it
// holds in the cycle the player presses the button.
module dice_counter #(
    parameter int DICE_MAX = 6
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          value <= 3'd1;
        else if (value == 3'(DICE_MAX))    value <= 3'd1;
        else                               value <= value + 3'd1;
    end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: rolls the dice, moves the active player, handshakes with the
// renderer via pos_valid/turn_done, applies the question-box bonus and detects a win.
module turn_sequencer #(
    parameter int NUM_TILES   = 10,
    parameter int TILE_X0     = 20,
    parameter int TILE_PITCH  = 60,
    parameter int DICE_MAX    = 6,
    parameter int QBOX_TILE   = 4,
    parameter int QBOX_BONUS  = 2,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_req,
    input  logic       turn_done,
    output logic [9:0] player1_pos_x,
    output logic [9:0] player2_pos_x,
    output logic       pos_valid,
    output logic       active_player,
    output logic [2:0] dice_value,
    output logic       busy,
    output logic       game_over,
    output logic       winner
);
    import game_pkg::*;

    localparam logic [TILE_W-1:0] GOAL     = TILE_W'(NUM_TILES - 1);
    localparam logic [TILE_W-1:0] QBOX     = TILE_W'(QBOX_TILE);
    localparam int                WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYC);
    localparam logic [X_W-1:0]    X_START  = X_W'(TILE_X0);

    state_t                       state_q, state_d;
    logic [1:0][TILE_W-1:0]       tile_q, tile_d;
    logic [TILE_W-1:0]            pending_q, pending_d;
    logic                         bonus_q, bonus_d;
    logic [WD_W-1:0]              wd_q, wd_d;
    logic [X_W-1:0]               p1_d, p2_d;
    logic                         valid_d, active_d, over_d, winner_d;
    logic [DICE_W-1:0]            dice_d, dice_now;
    logic [TILE_W-1:0]            cur_tile;

    dice_counter #(.DICE_MAX(DICE_MAX)) u_dice (
        .clk   (clk),
        .rst   (rst),
        .value (dice_now)
    );

    // Sum kept one bit wider so an overshoot past the goal clamps instead of wrapping.
    function automatic logic [TILE_W-1:0] advance(input logic [TILE_W-1:0] from,
                                                  input logic [TILE_W:0]   step);
        logic [TILE_W:0] sum;
        sum = {1'b0, from} + step;
        return (sum > {1'b0, GOAL}) ? GOAL : sum[TILE_W-1:0];
    endfunction

    assign cur_tile = tile_q[active_player];
    assign busy     = (state_q == ROLL) || (state_q == ISSUE) || (state_q == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            tile_q        <= '0;
            pending_q     <= '0;
            bonus_q       <= 1'b0;
            wd_q          <= '0;
            player1_pos_x <= X_START;
            player2_pos_x <= X_START;
            pos_valid     <= 1'b0;
            active_player <= 1'b0;
            dice_value    <= '0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tile_q        <= tile_d;
            pending_q     <= pending_d;
            bonus_q       <= bonus_d;
            wd_q          <= wd_d;
            player1_pos_x <= p1_d;
            player2_pos_x <= p2_d;
            pos_valid     <= valid_d;
            active_player <= active_d;
            dice_value    <= dice_d;
            game_over     <= over_d;
            winner        <= winner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        pending_d = pending_q;
        bonus_d   = bonus_q;
        wd_d      = wd_q;
        p1_d      = player1_pos_x;
        p2_d      = player2_pos_x;
        valid_d   = 1'b0;
        active_d  = active_player;
        dice_d    = dice_value;
        over_d    = game_over;
        winner_d  = winner;

        case (state_q)
            IDLE: begin
                if (roll_req) begin
                    dice_d    = dice_now;
                    pending_d = advance(cur_tile, {2'b00, dice_now});
                    bonus_d   = 1'b0;
                    state_d   = ROLL;
                end
            end
            ROLL: begin
                tile_d[active_player] = pending_q;
                if (active_player) p2_d = tile_to_x(pending_q, TILE_X0, TILE_PITCH);
                else               p1_d = tile_to_x(pending_q, TILE_X0, TILE_PITCH);
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (turn_done || (wd_q == WD_LIMIT)) begin
                    if (cur_tile == GOAL) begin
                        over_d   = 1'b1;
                        winner_d = active_player;
                        state_d  = OVER;
                    end else if ((cur_tile == QBOX) && !bonus_q) begin
                        pending_d = advance(cur_tile, (TILE_W+1)'(QBOX_BONUS));
                        bonus_d   = 1'b1;
                        state_d   = ROLL;
                    end else begin
                        active_d = ~active_player;
                        state_d  = IDLE;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

endmodule
